// File: rtl/spi_rd_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_rd_scheduler_if
// Brief    : Request-side and readout-FIFO bundle for spi_rd_scheduler.
// Revision : 1.0
// ============================================================================
interface spi_rd_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 12
);
    logic                     enable;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATA_W-1:0]   req_data;
    logic [NREQ-1:0]          req_ack;
    logic                     fifo_full;
    logic                     fifo_wr;
    logic [14:0]              fifo_din;
    logic [15:0]              words_sent;
    logic                     busy;

    // Requesters and FIFO side (testbench / surrounding logic).
    modport master (
        output enable, req_valid, req_data, fifo_full,
        input  req_ack, fifo_wr, fifo_din, words_sent, busy
    );

    // Scheduler side.
    modport slave (
        input  enable, req_valid, req_data, fifo_full,
        output req_ack, fifo_wr, fifo_din, words_sent, busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_rd_scheduler
// Brief    : Round-robin sharing of the SPI readout FIFO write port among
//            NREQ channels; optional idle heartbeat with SPI_HEARTBEAT_EN.
// Revision : 1.0
// ============================================================================
module spi_rd_scheduler #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 12,
    parameter int HB_PERIOD = 200000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    spi_rd_scheduler_if.slave  bus
);

`ifdef SPI_HEARTBEAT_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WRITE = 2'd2,
        S_HB    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WRITE = 2'd2
    } state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          rr_ptr;
    logic [1:0]          win_id;
    logic [1:0]          pick_id;
    logic                pick_vld;
    logic                start_req;
    logic [14:0]         din_q;
    logic [15:0]         words_q;
    logic [DATA_W-1:0]   grant_data;
    logic                fifo_wr;
    logic [NREQ-1:0]     req_ack;

    // Scan from rr_ptr upward; the lowest offset is evaluated last so it wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                pick_vld = 1'b1;
                pick_id  = 2'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign start_req  = bus.enable && pick_vld;
    assign grant_data = bus.req_data[int'(win_id) * DATA_W +: DATA_W];

`ifdef SPI_HEARTBEAT_EN
    localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

    logic [HB_W-1:0] idle_cnt;
    logic [11:0]     hb_seq;
    logic            idle_cond;
    logic            hb_fire;

    assign idle_cond = (state == S_IDLE) && bus.enable && !(|bus.req_valid);
    assign hb_fire   = idle_cond && (int'(idle_cnt) == HB_PERIOD - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            hb_seq   <= 12'd0;
        end else if (state == S_HB) begin
            idle_cnt <= '0;
            hb_seq   <= hb_seq + 12'd1;
        end else if (start_req && (state == S_IDLE)) begin
            idle_cnt <= '0;
        end else if (hb_fire) begin
            idle_cnt <= '0;
        end else if (idle_cond) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // HB_PERIOD only sizes the heartbeat timer, which is not built here.
    if (HB_PERIOD < 2) begin : g_hb_period_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fifo_wr   = 1'b0;
        req_ack   = '0;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_nxt = S_GRANT;
                end
`ifdef SPI_HEARTBEAT_EN
                else if (hb_fire) begin
                    state_nxt = S_HB;
                end
`endif
            end
            S_GRANT: begin
                req_ack   = NREQ'(1) << win_id;
                state_nxt = S_WRITE;
            end
`ifdef SPI_HEARTBEAT_EN
            S_HB: begin
                state_nxt = S_WRITE;
            end
`endif
            S_WRITE: begin
                // Reset in this cycle discards the word, so it must not strobe.
                if (!bus.fifo_full) begin
                    fifo_wr   = rst_n;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr  <= 2'd0;
            win_id  <= 2'd0;
            din_q   <= 15'd0;
            words_q <= 16'd0;
        end else begin
            if ((state == S_IDLE) && start_req) begin
                win_id <= pick_id;
            end
            if (state == S_GRANT) begin
                din_q  <= {1'b0, win_id, grant_data};
                rr_ptr <= (int'(win_id) == NREQ - 1) ? 2'd0 : win_id + 2'd1;
            end
`ifdef SPI_HEARTBEAT_EN
            if (state == S_HB) begin
                din_q <= {1'b1, 2'b00, hb_seq};
            end
`endif
            if (fifo_wr) begin
                words_q <= words_q + 16'd1;
            end
        end
    end

    assign bus.fifo_wr    = fifo_wr;
    assign bus.req_ack    = req_ack;
    assign bus.fifo_din   = din_q;
    assign bus.words_sent = words_q;
    assign bus.busy       = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_spi_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_rd_scheduler
// Brief    : Self-checking bench for spi_rd_scheduler (directed + random).
// Revision : 1.0
// ============================================================================
module tb_spi_rd_scheduler;
    localparam int NREQ      = 4;
    localparam int DATA_W    = 12;
    localparam int HB_PERIOD = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_rd_scheduler_if #(.NREQ(NREQ), .DATA_W(DATA_W)) sif ();

    spi_rd_scheduler #(
        .NREQ      (NREQ),
        .DATA_W    (DATA_W),
        .HB_PERIOD (HB_PERIOD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] hb_exp   = 12'd0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [11:0] d);
        sif.req_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n  = 1'b1;
        hb_exp = 12'd0;
    endtask

    task automatic test_reset();
        sif.enable    = 1'b1;
        sif.req_valid = 4'hF;
        sif.fifo_full = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (sif.req_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", sif.req_ack); end
        n_checks++; if (sif.fifo_wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", sif.fifo_wr); end
        n_checks++; if (sif.words_sent !== 16'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", sif.words_sent); end
        n_checks++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", sif.busy); end
        n_checks++; if (sif.fifo_din !== 15'd0) begin n_fail++; $display("FAIL reset_din: got %h want 0000", sif.fifo_din); end
        sif.req_valid = 4'h0;
        rst_n  = 1'b1;
        hb_exp = 12'd0;
        tick();
    endtask

    task automatic test_single();
        set_data(2, 12'hABC);
        sif.req_valid = 4'b0100;
        tick();
        n_checks++; if (sif.req_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b want 0100", sif.req_ack); end
        tick();
        sif.req_valid = 4'b0000;
        n_checks++; if (sif.fifo_wr !== 1'b1) begin n_fail++; $display("FAIL single_wr: got %b want 1", sif.fifo_wr); end
        n_checks++; if (sif.fifo_din !== 15'h2ABC) begin n_fail++; $display("FAIL single_din: got %h want 2abc", sif.fifo_din); end
        tick();
        n_checks++; if (sif.words_sent !== 16'd1) begin n_fail++; $display("FAIL single_words: got %0d want 1", sif.words_sent); end
        n_checks++; if (sif.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: busy %b want 0", sif.busy); end
        n_checks++; if (sif.fifo_din !== 15'h2ABC) begin n_fail++; $display("FAIL single_hold: got %h want 2abc", sif.fifo_din); end
    endtask

    task automatic test_backpressure();
        logic [11:0] d;
        logic [14:0] w;
        d = 12'($urandom);
        w = {1'b0, 2'd1, d};
        sif.fifo_full = 1'b1;
        set_data(1, d);
        sif.req_valid = 4'b0010;
        tick();
        n_checks++; if (sif.req_ack !== 4'b0010) begin n_fail++; $display("FAIL bp_ack: got %b want 0010", sif.req_ack); end
        tick();
        sif.req_valid = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (sif.fifo_wr !== 1'b0 || sif.fifo_din !== w || sif.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: wr=%b din=%h busy=%b want wr=0 din=%h busy=1", i, sif.fifo_wr, sif.fifo_din, sif.busy, w);
            end
            tick();
        end
        sif.fifo_full = 1'b0;
        #1;
        n_checks++; if (sif.fifo_wr !== 1'b1) begin n_fail++; $display("FAIL bp_release_wr: got %b want 1", sif.fifo_wr); end
        tick();
        n_checks++; if (sif.words_sent !== 16'd2) begin n_fail++; $display("FAIL bp_words: got %0d want 2", sif.words_sent); end
    endtask

    task automatic test_fairness();
        logic [14:0]     exp_q[$];
        logic [14:0]     w;
        logic [NREQ-1:0] ack_prev;
        logic [NREQ-1:0] exp_ack;
        int              cnt[NREQ];
        int              acks;
        int              writes;
        apply_reset();
        sif.enable    = 1'b1;
        sif.fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            set_data(i, 12'($urandom));
            cnt[i] = 0;
        end
        sif.req_valid = '1;
        acks = 0; writes = 0; ack_prev = '0;
        for (int c = 0; c < 80 && writes < 12; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) if (ack_prev[i]) set_data(i, 12'($urandom));
            #1;
            if (sif.req_ack != '0) begin
                exp_ack = NREQ'(1) << (acks % NREQ);
                n_checks++;
                if (sif.req_ack !== exp_ack) begin n_fail++; $display("FAIL fair_order[%0d]: got %b want %b", acks, sif.req_ack, exp_ack); end
                for (int i = 0; i < NREQ; i++) if (sif.req_ack[i]) cnt[i]++;
                exp_q.push_back({1'b0, 2'(acks % NREQ), sif.req_data[(acks % NREQ)*DATA_W +: DATA_W]});
                acks++;
            end
            ack_prev = sif.req_ack;
            if (sif.fifo_wr === 1'b1) begin
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h7FFF;
                n_checks++;
                if (sif.fifo_din !== w) begin n_fail++; $display("FAIL fair_data[%0d]: got %h want %h", writes, sif.fifo_din, w); end
                writes++;
            end
        end
        sif.req_valid = '0;
        n_checks++; if (writes != 12) begin n_fail++; $display("FAIL fair_writes: got %0d want 12", writes); end
        for (int i = 0; i < NREQ; i++) begin
            n_checks++; if (cnt[i] != 3) begin n_fail++; $display("FAIL fair_count[%0d]: got %0d want 3", i, cnt[i]); end
        end
        tick();
        tick();
        n_checks++; if (sif.words_sent !== 16'd12) begin n_fail++; $display("FAIL fair_words: got %0d want 12", sif.words_sent); end
    endtask

    task automatic test_enable_reset();
        logic [11:0] d;
        apply_reset();
        sif.enable = 1'b1; sif.fifo_full = 1'b0;
        d = 12'($urandom);
        set_data(0, d);
        sif.req_valid = 4'b0001;
        tick();
        n_checks++; if (sif.req_ack !== 4'b0001) begin n_fail++; $display("FAIL en_ack: got %b want 0001", sif.req_ack); end
        sif.enable = 1'b0;
        tick();
        sif.req_valid = 4'b1000;
        n_checks++;
        if (sif.fifo_wr !== 1'b1 || sif.fifo_din !== {1'b0, 2'd0, d}) begin
            n_fail++; $display("FAIL en_complete: wr=%b din=%h want wr=1 din=%h", sif.fifo_wr, sif.fifo_din, {1'b0, 2'd0, d});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (sif.req_ack !== 4'b0000 || sif.busy !== 1'b0) begin
                n_fail++; $display("FAIL en_hold[%0d]: ack=%b busy=%b want 0000/0", i, sif.req_ack, sif.busy);
            end
        end
        sif.enable = 1'b1; sif.fifo_full = 1'b1;
        tick();
        n_checks++; if (sif.req_ack !== 4'b1000) begin n_fail++; $display("FAIL rst_pre_ack: got %b want 1000", sif.req_ack); end
        tick();
        rst_n = 1'b0; sif.fifo_full = 1'b0;
        #1;
        n_checks++; if (sif.fifo_wr !== 1'b0) begin n_fail++; $display("FAIL rst_no_wr: got %b want 0", sif.fifo_wr); end
        tick();
        rst_n = 1'b1; sif.req_valid = 4'hF;
        n_checks++;
        if (sif.busy !== 1'b0 || sif.words_sent !== 16'd0 || sif.fifo_din !== 15'd0) begin
            n_fail++; $display("FAIL rst_state: busy=%b words=%0d din=%h want 0/0/0", sif.busy, sif.words_sent, sif.fifo_din);
        end
        tick();
        n_checks++; if (sif.req_ack !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr: got %b want 0001", sif.req_ack); end
        tick();
        sif.req_valid = 4'h0;
        tick();
        n_checks++; if (sif.words_sent !== 16'd1) begin n_fail++; $display("FAIL rst_words: got %0d want 1", sif.words_sent); end
    endtask

    task automatic test_random();
        logic [14:0]     exp_q[$];
        logic [14:0]     w;
        logic [NREQ-1:0] prev_valid;
        logic [NREQ-1:0] ack_prev;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] exp_ack;
        logic            prev_en;
        logic            hb;
        int              ptr;
        int              win;
        int              sent;
        bit              done;
        apply_reset();
        sif.req_valid = '0; sif.fifo_full = 1'b0; sif.enable = 1'b1;
        ptr = 0; sent = 0; ack_prev = '0; done = 1'b0;
        for (int c = 0; c < 800 && !done; c++) begin
            prev_valid = sif.req_valid;
            prev_en    = sif.enable;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (ack_prev[i]) begin
                    if (c < 600 && $urandom_range(1, 0) == 1) set_data(i, 12'($urandom));
                    else sif.req_valid[i] = 1'b0;
                end else if (!sif.req_valid[i] && c < 600 && $urandom_range(2, 0) == 0) begin
                    set_data(i, 12'($urandom));
                    sif.req_valid[i] = 1'b1;
                end
            end
            if (c < 600) begin
                sif.fifo_full = ($urandom_range(3, 0) == 0);
                sif.enable    = ($urandom_range(7, 0) != 0);
            end else begin
                sif.fifo_full = 1'b0;
                sif.enable    = 1'b1;
            end
            #1;
            ack = sif.req_ack;
            if (ack != '0) begin
                win     = prev_en ? rr_pick(prev_valid, ptr) : -1;
                exp_ack = (win >= 0) ? (NREQ'(1) << win) : '0;
                n_checks++;
                if (ack !== exp_ack) begin n_fail++; $display("FAIL rand_grant@%0d: got %b want %b", c, ack, exp_ack); end
                if (win >= 0) begin
                    exp_q.push_back({1'b0, 2'(win), sif.req_data[win*DATA_W +: DATA_W]});
                    ptr = (win + 1) % NREQ;
                end
            end
            ack_prev = ack;
            n_checks++;
            if (sif.words_sent !== 16'(sent)) begin n_fail++; $display("FAIL rand_words@%0d: got %0d want %0d", c, sif.words_sent, sent); end
            if (sif.fifo_wr === 1'b1) begin
                n_checks++;
                if (sif.fifo_full !== 1'b0) begin n_fail++; $display("FAIL rand_wr_full@%0d: wr=1 full=%b want full=0", c, sif.fifo_full); end
                hb = 1'b0;
`ifdef SPI_HEARTBEAT_EN
                hb = sif.fifo_din[14];
`endif
                w = 15'h7FFF;
                if (hb) begin
                    w = {1'b1, 2'b00, hb_exp};
                    hb_exp = hb_exp + 12'd1;
                end else if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                end else begin
                    n_fail++; $display("FAIL rand_extra_wr@%0d: din=%h with no word expected", c, sif.fifo_din);
                end
                n_checks++;
                if (sif.fifo_din !== w) begin n_fail++; $display("FAIL rand_data@%0d: got %h want %h", c, sif.fifo_din, w); end
                sent++;
            end
            if (c >= 600 && exp_q.size() == 0 && sif.req_valid == '0 && ack_prev == '0 && sif.busy === 1'b0) done = 1'b1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL rand_drain: done=%0d want 1 (pending %0d)", done, exp_q.size()); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_left: got %0d want 0", exp_q.size()); end
    endtask

`ifdef SPI_HEARTBEAT_EN
    task automatic test_heartbeat();
        int          cyc;
        int          nwr;
        logic [11:0] d;
        sif.enable = 1'b1; sif.req_valid = '0; sif.fifo_full = 1'b0;
        apply_reset();
        cyc = 0;
        do begin tick(); cyc++; end while (sif.fifo_wr !== 1'b1 && cyc < 60);
        n_checks++; if (cyc != HB_PERIOD + 1) begin n_fail++; $display("FAIL hb_first_time: got %0d want %0d", cyc, HB_PERIOD + 1); end
        n_checks++; if (sif.fifo_din !== 15'h4000) begin n_fail++; $display("FAIL hb_first_din: got %h want 4000", sif.fifo_din); end
        cyc = 0;
        do begin tick(); cyc++; end while (sif.fifo_wr !== 1'b1 && cyc < 60);
        n_checks++; if (cyc != HB_PERIOD + 2) begin n_fail++; $display("FAIL hb_second_time: got %0d want %0d", cyc, HB_PERIOD + 2); end
        n_checks++; if (sif.fifo_din !== 15'h4001) begin n_fail++; $display("FAIL hb_second_din: got %h want 4001", sif.fifo_din); end
        set_data(0, 12'($urandom));
        sif.req_valid = 4'b0001;
        nwr = 0;
        for (int c = 0; c < 100; c++) begin
            if (sif.req_ack[0] === 1'b1) begin
                tick();
                d = 12'($urandom);
                set_data(0, d);
            end else begin
                tick();
            end
            if (sif.fifo_wr === 1'b1) begin
                nwr++;
                n_checks++;
                if (sif.fifo_din[14] !== 1'b0) begin n_fail++; $display("FAIL hb_busy_type@%0d: din=%h want type 0", c, sif.fifo_din); end
            end
        end
        n_checks++; if (nwr < 30) begin n_fail++; $display("FAIL hb_busy_rate: got %0d writes want >=30", nwr); end
        sif.req_valid = '0;
        tick(); tick(); tick();
    endtask
`else
    task automatic test_no_heartbeat();
        sif.enable = 1'b1; sif.req_valid = '0; sif.fifo_full = 1'b0;
        apply_reset();
        for (int c = 0; c < 3 * HB_PERIOD; c++) begin
            tick();
            n_checks++;
            if (sif.fifo_wr !== 1'b0 || sif.busy !== 1'b0) begin
                n_fail++; $display("FAIL no_hb@%0d: wr=%b busy=%b want 0/0", c, sif.fifo_wr, sif.busy);
            end
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        sif.enable    = 1'b0;
        sif.req_valid = '0;
        sif.req_data  = '0;
        sif.fifo_full = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_fairness();
        test_enable_reset();
        test_random();
`ifdef SPI_HEARTBEAT_EN
        test_heartbeat();
`else
        test_no_heartbeat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
